// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared helpers for the branch history table (address split, counter steps).
package branch_predictor_pkg;
  function automatic int weak_taken(input int w);
    return 1 << (w - 1);
  endfunction
  function automatic logic [63:0] idx_of(input logic [63:0] a, input int iw);
    return (a >> 2) & ((64'd1 << iw) - 64'd1);
  endfunction
  function automatic logic [63:0] tag_of(input logic [63:0] a, input int iw);
    return a >> (iw + 2);
  endfunction
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    return (v == ((64'd1 << w) - 64'd1)) ? v : v + 64'd1;
  endfunction
  function automatic logic [63:0] sat_dec(input logic [63:0] v);
    return (v == 64'd0) ? v : v - 64'd1;
  endfunction
endpackage

// File: rtl/bp_sat_counter.sv
// bp_sat_counter: W-bit saturating counter.
//   clk/rst (async) - clock and reset; clr - sync clear; ld/ld_val - load;
//   inc/dec - saturating step up/down; q - count.
module bp_sat_counter
  import branch_predictor_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] q
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb
    cnt_d = clr ? '0 : ld ? ld_val : inc ? W'(sat_inc(64'(cnt_q), W)) :
            dec ? W'(sat_dec(64'(cnt_q))) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign q = cnt_q;
endmodule

// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht: direct-mapped branch history table + target buffer.
//   iSEARCH_* - lookup request, registered result on oSEARCH_* (holdable by lock);
//   iJUMP_*   - resolved branch training; iFLUSH - invalidate all lines;
//   oSTAT_*   - saturating update / mispredict counts.
module branch_predictor_bht
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              iCLOCK,
  input  logic              iRESET,
  input  logic              iRESET_SYNC,
  input  logic              iFLUSH,
  input  logic              iSEARCH_STB,
  input  logic [ADDR_W-1:0] iSEARCH_INST_ADDR,
  input  logic              iSEARCH_LOCK,
  output logic              oSEARCH_VALID,
  output logic              oSEARCH_HIT,
  output logic              oSEARCH_PREDICT_BRANCH,
  output logic [ADDR_W-1:0] oSEARCH_ADDR,
  input  logic              iJUMP_STB,
  input  logic              iJUMP_PREDICT,
  input  logic              iJUMP_JUMP,
  input  logic [ADDR_W-1:0] iJUMP_ADDR,
  input  logic [ADDR_W-1:0] iJUMP_INST_ADDR,
  output logic [STAT_W-1:0] oSTAT_UPDATES,
  output logic [STAT_W-1:0] oSTAT_MISPREDICT
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  logic [IDX_W-1:0] s_idx, j_idx;
  logic [TAG_W-1:0] s_tag, j_tag;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [ENTRIES];
  logic [TAG_W-1:0] tag_d [ENTRIES];
  logic [ADDR_W-1:0] tgt_q [ENTRIES];
  logic [ADDR_W-1:0] tgt_d [ENTRIES];
  logic [CNT_W-1:0] cnt [ENTRIES];
  logic s_hit, j_hit, upd, alloc;
  logic s_valid_q, s_valid_d, s_hit_q, s_hit_d, s_pred_q, s_pred_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  assign s_idx = IDX_W'(idx_of(64'(iSEARCH_INST_ADDR), IDX_W));
  assign s_tag = TAG_W'(tag_of(64'(iSEARCH_INST_ADDR), IDX_W));
  assign j_idx = IDX_W'(idx_of(64'(iJUMP_INST_ADDR), IDX_W));
  assign j_tag = TAG_W'(tag_of(64'(iJUMP_INST_ADDR), IDX_W));
  assign s_hit = valid_q[s_idx] && tag_q[s_idx] == s_tag;
  assign j_hit = valid_q[j_idx] && tag_q[j_idx] == j_tag;
  // updates coinciding with a flush are dropped from the table (stats still count them)
  assign upd   = iJUMP_STB && !iFLUSH;
  assign alloc = upd && !j_hit && iJUMP_JUMP;
  // taken: hit overwrites target, miss allocates; tag/valid rewrite is a no-op on hit
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (iRESET_SYNC) begin
      valid_d = '0;
      tag_d   = '{default: '0};
      tgt_d   = '{default: '0};
    end else if (iFLUSH) valid_d = '0;
    else if (upd && iJUMP_JUMP) begin
      valid_d[j_idx] = 1'b1;
      tag_d[j_idx]   = j_tag;
      tgt_d[j_idx]   = iJUMP_ADDR;
    end
  end
  always_ff @(posedge iCLOCK or posedge iRESET)
    if (iRESET) begin
      valid_q <= '0;
      tag_q   <= '{default: '0};
      tgt_q   <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
    end
  for (genvar i = 0; i < ENTRIES; i++) begin : g_line
    bp_sat_counter #(.W(CNT_W)) u_cnt (
      .clk(iCLOCK), .rst(iRESET), .clr(iRESET_SYNC),
      .ld(alloc && j_idx == IDX_W'(i)),
      .ld_val(CNT_W'(weak_taken(CNT_W))),
      .inc(upd && j_hit && iJUMP_JUMP && j_idx == IDX_W'(i)),
      .dec(upd && j_hit && !iJUMP_JUMP && j_idx == IDX_W'(i)),
      .q(cnt[i])
    );
  end
  always_comb begin
    s_valid_d = iRESET_SYNC ? 1'b0 : iSEARCH_LOCK ? s_valid_q : iSEARCH_STB;
    s_hit_d   = iRESET_SYNC ? 1'b0 : iSEARCH_LOCK ? s_hit_q : iSEARCH_STB && s_hit;
    s_pred_d  = iRESET_SYNC ? 1'b0 : iSEARCH_LOCK ? s_pred_q :
                iSEARCH_STB && s_hit && cnt[s_idx][CNT_W-1];
    s_addr_d  = iRESET_SYNC ? '0 : iSEARCH_LOCK ? s_addr_q :
                (iSEARCH_STB && s_hit) ? tgt_q[s_idx] : '0;
  end
  always_ff @(posedge iCLOCK or posedge iRESET)
    if (iRESET) begin
      s_valid_q <= 1'b0;
      s_hit_q   <= 1'b0;
      s_pred_q  <= 1'b0;
      s_addr_q  <= '0;
    end else begin
      s_valid_q <= s_valid_d;
      s_hit_q   <= s_hit_d;
      s_pred_q  <= s_pred_d;
      s_addr_q  <= s_addr_d;
    end
  assign oSEARCH_VALID          = s_valid_q;
  assign oSEARCH_HIT            = s_hit_q;
  assign oSEARCH_PREDICT_BRANCH = s_pred_q;
  assign oSEARCH_ADDR           = s_addr_q;
  bp_sat_counter #(.W(STAT_W)) u_stat_upd (
    .clk(iCLOCK), .rst(iRESET), .clr(iRESET_SYNC), .ld(1'b0), .ld_val('0),
    .inc(iJUMP_STB), .dec(1'b0), .q(oSTAT_UPDATES)
  );
  bp_sat_counter #(.W(STAT_W)) u_stat_mis (
    .clk(iCLOCK), .rst(iRESET), .clr(iRESET_SYNC), .ld(1'b0), .ld_val('0),
    .inc(iJUMP_STB && iJUMP_PREDICT != iJUMP_JUMP), .dec(1'b0), .q(oSTAT_MISPREDICT)
  );
endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb_branch_predictor_bht: directed self-checking bench for branch_predictor_bht.
module tb_branch_predictor_bht;
  logic iCLOCK = 1'b0, iRESET = 1'b1, iRESET_SYNC = 1'b0, iFLUSH = 1'b0;
  logic iSEARCH_STB = 1'b0, iSEARCH_LOCK = 1'b0;
  logic [31:0] iSEARCH_INST_ADDR = '0;
  logic oSEARCH_VALID, oSEARCH_HIT, oSEARCH_PREDICT_BRANCH;
  logic [31:0] oSEARCH_ADDR;
  logic iJUMP_STB = 1'b0, iJUMP_PREDICT = 1'b0, iJUMP_JUMP = 1'b0;
  logic [31:0] iJUMP_ADDR = '0, iJUMP_INST_ADDR = '0;
  logic [3:0] oSTAT_UPDATES, oSTAT_MISPREDICT;
  int n_chk = 0, n_pass = 0;
  int n_upd = 0, n_mis = 0;
  branch_predictor_bht #(.STAT_W(4)) dut (
    .iCLOCK(iCLOCK), .iRESET(iRESET), .iRESET_SYNC(iRESET_SYNC), .iFLUSH(iFLUSH),
    .iSEARCH_STB(iSEARCH_STB), .iSEARCH_INST_ADDR(iSEARCH_INST_ADDR),
    .iSEARCH_LOCK(iSEARCH_LOCK), .oSEARCH_VALID(oSEARCH_VALID), .oSEARCH_HIT(oSEARCH_HIT),
    .oSEARCH_PREDICT_BRANCH(oSEARCH_PREDICT_BRANCH), .oSEARCH_ADDR(oSEARCH_ADDR),
    .iJUMP_STB(iJUMP_STB), .iJUMP_PREDICT(iJUMP_PREDICT), .iJUMP_JUMP(iJUMP_JUMP),
    .iJUMP_ADDR(iJUMP_ADDR), .iJUMP_INST_ADDR(iJUMP_INST_ADDR),
    .oSTAT_UPDATES(oSTAT_UPDATES), .oSTAT_MISPREDICT(oSTAT_MISPREDICT)
  );
  always #5 iCLOCK = ~iCLOCK;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic search(input logic [31:0] a);
    @(negedge iCLOCK);
    iSEARCH_STB = 1'b1;
    iSEARCH_INST_ADDR = a;
    @(posedge iCLOCK);
    #1 iSEARCH_STB = 1'b0;
  endtask
  task automatic drive_upd(input logic [31:0] a, input logic j, input logic [31:0] t, input logic p);
    iJUMP_STB = 1'b1;
    iJUMP_INST_ADDR = a;
    iJUMP_JUMP = j;
    iJUMP_ADDR = t;
    iJUMP_PREDICT = p;
    n_upd = (n_upd == 15) ? 15 : n_upd + 1;
    if (p != j) n_mis = (n_mis == 15) ? 15 : n_mis + 1;
  endtask
  task automatic update(input logic [31:0] a, input logic j, input logic [31:0] t, input logic p);
    @(negedge iCLOCK);
    drive_upd(a, j, t, p);
    @(posedge iCLOCK);
    #1 iJUMP_STB = 1'b0;
  endtask
  task automatic chk_stats(input string tag);
    chk({tag, "_upd"}, 64'(oSTAT_UPDATES), 64'(n_upd));
    chk({tag, "_mis"}, 64'(oSTAT_MISPREDICT), 64'(n_mis));
  endtask
  initial begin
    repeat (2) @(posedge iCLOCK);
    #1;
    chk("rst_valid", 64'(oSEARCH_VALID), 0);
    chk("rst_hit", 64'(oSEARCH_HIT), 0);
    chk("rst_pred", 64'(oSEARCH_PREDICT_BRANCH), 0);
    chk("rst_addr", 64'(oSEARCH_ADDR), 0);
    chk_stats("rst");
    @(negedge iCLOCK) iRESET = 1'b0;
    search(32'h100);
    chk("miss_valid", 64'(oSEARCH_VALID), 1);
    chk("miss_hit", 64'(oSEARCH_HIT), 0);
    chk("miss_pred", 64'(oSEARCH_PREDICT_BRANCH), 0);
    chk("miss_addr", 64'(oSEARCH_ADDR), 0);
    update(32'h100, 1, 32'h2000, 0);
    search(32'h100);
    chk("alloc_hit", 64'(oSEARCH_HIT), 1);
    chk("alloc_pred", 64'(oSEARCH_PREDICT_BRANCH), 1);
    chk("alloc_addr", 64'(oSEARCH_ADDR), 32'h2000);
    chk_stats("alloc");
    update(32'h100, 0, 32'h9990, 1);
    update(32'h100, 0, 32'h9990, 1);
    search(32'h100);
    chk("nt2_hit", 64'(oSEARCH_HIT), 1);
    chk("nt2_pred", 64'(oSEARCH_PREDICT_BRANCH), 0);
    chk("nt2_addr", 64'(oSEARCH_ADDR), 32'h2000);
    update(32'h100, 0, 32'h0, 0);
    update(32'h100, 1, 32'h2000, 0);
    search(32'h100);
    chk("floor_pred", 64'(oSEARCH_PREDICT_BRANCH), 0);
    update(32'h100, 1, 32'h2000, 1);
    search(32'h100);
    chk("t2_pred", 64'(oSEARCH_PREDICT_BRANCH), 1);
    repeat (4) update(32'h100, 1, 32'h2000, 1);
    search(32'h100);
    chk("sat_pred", 64'(oSEARCH_PREDICT_BRANCH), 1);
    update(32'h100, 0, 32'h0, 1);
    search(32'h100);
    chk("sat_dec_pred", 64'(oSEARCH_PREDICT_BRANCH), 1);
    chk_stats("train");
    update(32'h120, 1, 32'h3000, 0);
    search(32'h100);
    chk("alias_old_hit", 64'(oSEARCH_HIT), 0);
    search(32'h120);
    chk("alias_new_hit", 64'(oSEARCH_HIT), 1);
    chk("alias_new_addr", 64'(oSEARCH_ADDR), 32'h3000);
    chk("alias_new_pred", 64'(oSEARCH_PREDICT_BRANCH), 1);
    update(32'h100, 1, 32'h2000, 1);
    search(32'h100);
    chk("relock_hit", 64'(oSEARCH_HIT), 1);
    @(negedge iCLOCK);
    iSEARCH_LOCK = 1'b1;
    iSEARCH_STB = 1'b1;
    iSEARCH_INST_ADDR = 32'h140;
    @(posedge iCLOCK);
    #1;
    chk("lock_hit", 64'(oSEARCH_HIT), 1);
    chk("lock_addr", 64'(oSEARCH_ADDR), 32'h2000);
    iSEARCH_STB = 1'b0;
    iSEARCH_LOCK = 1'b0;
    @(negedge iCLOCK);
    iFLUSH = 1'b1;
    drive_upd(32'h160, 1, 32'h4000, 0);
    @(posedge iCLOCK);
    #1 iFLUSH = 1'b0;
    iJUMP_STB = 1'b0;
    search(32'h100);
    chk("flush_hit", 64'(oSEARCH_HIT), 0);
    search(32'h160);
    chk("flush_upd_drop", 64'(oSEARCH_HIT), 0);
    chk_stats("flush");
    update(32'h100, 1, 32'h2000, 1);
    @(negedge iCLOCK);
    iSEARCH_STB = 1'b1;
    iSEARCH_INST_ADDR = 32'h100;
    drive_upd(32'h100, 1, 32'h5000, 1);
    @(posedge iCLOCK);
    #1 iSEARCH_STB = 1'b0;
    iJUMP_STB = 1'b0;
    chk("same_cyc_old", 64'(oSEARCH_ADDR), 32'h2000);
    search(32'h100);
    chk("next_cyc_new", 64'(oSEARCH_ADDR), 32'h5000);
    for (int i = 0; i < 20; i++) update(32'h200, i[0], 32'h6000, ~i[0]);
    chk_stats("stat_sat");
    chk("stat_sat_lit", 64'(oSTAT_MISPREDICT), 15);
    search(32'h100);
    @(negedge iCLOCK);
    iSEARCH_LOCK = 1'b1;
    drive_upd(32'h100, 1, 32'h7000, 0);
    #1 iRESET = 1'b1;
    #1;
    chk("arst_hit", 64'(oSEARCH_HIT), 0);
    chk("arst_valid", 64'(oSEARCH_VALID), 0);
    chk("arst_addr", 64'(oSEARCH_ADDR), 0);
    chk("arst_upd", 64'(oSTAT_UPDATES), 0);
    chk("arst_mis", 64'(oSTAT_MISPREDICT), 0);
    iJUMP_STB = 1'b0;
    iSEARCH_LOCK = 1'b0;
    n_upd = 0;
    n_mis = 0;
    @(negedge iCLOCK) iRESET = 1'b0;
    search(32'h100);
    chk("arst_table", 64'(oSEARCH_HIT), 0);
    update(32'h100, 1, 32'h2000, 0);
    search(32'h100);
    chk("post_rst_hit", 64'(oSEARCH_HIT), 1);
    @(negedge iCLOCK);
    iRESET_SYNC = 1'b1;
    iSEARCH_LOCK = 1'b1;
    @(posedge iCLOCK);
    #1 iRESET_SYNC = 1'b0;
    iSEARCH_LOCK = 1'b0;
    chk("srst_hit", 64'(oSEARCH_HIT), 0);
    chk("srst_upd", 64'(oSTAT_UPDATES), 0);
    search(32'h100);
    chk("srst_table", 64'(oSEARCH_HIT), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/branch_predictor_bht.md
# branch_predictor_bht

Parametrised branch history table and target buffer for the fetch stage. The table is direct-mapped with ENTRIES lines, and each line holds a tag, a target address and a CNT_W-bit saturating counter. A search returns a registered prediction one cycle after the strobe, and that result can be held by a fetch stall. Resolved branches from execute train the table, and two saturating statistics counters report update and mispredict counts.

## Interface
- ENTRIES, 8, number of table lines; power of two, ≥2; IDX_W = log2(ENTRIES)
- ADDR_W, 32, instruction/target address width
- CNT_W, 2, saturating counter width; ≥1
- STAT_W, 16, width of each statistics counter
- iCLOCK  in  1  single clock; all state changes on rising edge
- iRESET  in  1  asynchronous, active-high reset
- iRESET_SYNC  in  1  synchronous clear, same effect as iRESET
- iFLUSH  in  1  invalidate all lines
- iSEARCH_STB  in  1  lookup request
- iSEARCH_INST_ADDR  in  ADDR_W  fetch address
- iSEARCH_LOCK  in  1  hold registered search outputs
- oSEARCH_VALID  out  1  registered iSEARCH_STB
- oSEARCH_HIT  out  1  line valid and tag match
- oSEARCH_PREDICT_BRANCH  out  1  hit AND counter MSB
- oSEARCH_ADDR  out  ADDR_W  stored target (0 on miss)
- iJUMP_STB  in  1  resolved-branch update
- iJUMP_PREDICT  in  1  prediction fetch used for this branch
- iJUMP_JUMP  in  1  branch actually taken
- iJUMP_ADDR  in  ADDR_W  actual target
- iJUMP_INST_ADDR  in  ADDR_W  branch instruction address
- oSTAT_UPDATES  out  STAT_W  count of iJUMP_STB, saturating
- oSTAT_MISPREDICT  out  STAT_W  count of iJUMP_PREDICT != iJUMP_JUMP, saturating

## Operation
- Address split: index = addr[IDX_W+1:2]; tag = addr[ADDR_W-1:IDX_W+2]; addr[1:0] is ignored.
- Reset (iRESET or iRESET_SYNC) clears the following to 0:
  - every valid bit, tag, target and counter
  - all outputs and both stat counters
- Search:
  - The lookup is combinational on the current table.
  - The result is registered only when iSEARCH_LOCK=0. Under lock, all four search outputs hold their values.
  - With iSEARCH_STB=0 and no lock, the register loads VALID=0, HIT=0, PREDICT=0 and ADDR=0.
- Update on iJUMP_STB:
  - Hit and taken: counter +1, saturating at 2^CNT_W−1. Target is overwritten with iJUMP_ADDR.
  - Hit and not taken: counter −1, saturating at 0. Target is unchanged.
  - Miss and taken: the line is allocated or replaced. valid=1, tag and target are written, counter = weak-taken (1<<(CNT_W−1)).
  - Miss and not taken: no table change.
- Stats: oSTAT_UPDATES increments on each iJUMP_STB. oSTAT_MISPREDICT increments when iJUMP_STB and iJUMP_PREDICT!=iJUMP_JUMP. Both hold at 2^STAT_W−1.
- iFLUSH clears all valid bits. Tags, targets, counters and stats are retained.
- Priority: reset > iFLUSH > update. An update in a flush cycle is dropped, but the stats still count it.

## Timing
- Search latency is 1 cycle: strobe at edge N, outputs valid after edge N+1.
- A search and an update to the same index in the same cycle return pre-update contents. The new contents are visible to a search issued the next cycle.
- A flush and a search in the same cycle: the search returns pre-flush contents. The next search misses.
- iRESET takes effect immediately, even mid-update or under lock. iRESET_SYNC takes effect at the next edge and overrides lock.
- Lock does not block updates or flush. Held outputs may therefore be stale relative to the table.

## Structure
- The package branch_predictor_pkg holds:
  - the weak-taken constant function of CNT_W
  - the index/tag extraction functions
  - the saturating increment/decrement helpers
- Sub-module bp_sat_counter (width parameter; inc/dec/load/clear) is instantiated per line and for both stat counters.
- The table is stored as flop arrays. Valid bits are individual flops so that flush completes in one cycle.

## Test plan
All scenarios use ENTRIES=8: index = bits [4:2], tag = bits [31:5].

1. Reset, then search 0x100 → next cycle VALID=1, HIT=0, PREDICT=0, ADDR=0x0.
2. Update 0x100 taken, target 0x2000; then search 0x100 → HIT=1, PREDICT=1, ADDR=0x2000 (counter=2).
3. Counter training:
   - Two not-taken updates on 0x100 → PREDICT=0, HIT=1.
   - A third not-taken keeps counter=0.
   - Two taken updates → counter=2, PREDICT=1.
   - Four taken updates → counter=3, not 0.
4. Alias: taken update on 0x120 (index 0, new tag), target 0x3000 → search 0x100 HIT=0; search 0x120 ADDR=0x3000.
5. Lock and flush:
   - Search 0x100 hit, then raise iSEARCH_LOCK and search 0x140 → outputs stay HIT=1, ADDR=0x2000.
   - Release lock, assert iFLUSH, then search 0x100 → HIT=0.
   - An update in the same cycle as iFLUSH leaves the table unchanged.
6. Same-cycle search/update to 0x100 returns the old target, and the next-cycle search returns the new one. With STAT_W=4, 20 mispredicting updates → oSTAT_MISPREDICT=15 and oSTAT_UPDATES=15; async iRESET mid-sequence → all zero.
